// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths.
// Used by the byte assembler and the block-to-byte splitter.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  typedef logic [AES_BYTE_W-1:0]  byte_t;
  typedef logic [AES_BLOCK_W-1:0] block_t;

endpackage

// File: rtl/aes_byte_assembler_if.sv
// Byte-in / block-out valid-ready bundle for the AES byte assembler.
// slave: the assembler side; master: the host/consumer side.
//   in_byte/in_valid/in_ready/in_abort : byte stream in
//   out_block/out_valid/out_ready      : block stream out
//   fill_count                         : bytes in the partial block
interface aes_byte_assembler_if
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = AES_NUM_BYTES,
  parameter int BYTE_W    = AES_BYTE_W
);

  localparam int BLK_W = NUM_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(NUM_BYTES);

  logic [BYTE_W-1:0] in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              in_abort;
  logic [BLK_W-1:0]  out_block;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  fill_count;

  modport master (
    output in_byte,
    output in_valid,
    output in_abort,
    output out_ready,
    input  in_ready,
    input  out_block,
    input  out_valid,
    input  fill_count
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    input  in_abort,
    input  out_ready,
    output in_ready,
    output out_block,
    output out_valid,
    output fill_count
  );

endinterface

// File: rtl/aes_byte_assembler.sv
// Collects NUM_BYTES bytes into one block, first byte at the MSB.
// Ports: clk, rst (sync, active high), bus (slave modport).
module aes_byte_assembler
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = AES_NUM_BYTES,
  parameter int BYTE_W    = AES_BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_byte_assembler_if.slave   bus
);

  localparam int BLK_W = NUM_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(NUM_BYTES);
  localparam int PTR_W = $clog2(BLK_W);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_BYTES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_acc;
  logic [BLK_W-1:0] r_out_block;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_done;
  logic [PTR_W-1:0] w_msb;

  // Only the completing byte needs the output
  // register; earlier bytes buffer in r_acc.
  assign w_in_ready = (r_cnt != LAST)
                    | ~r_out_valid
                    | bus.out_ready;

  assign w_accept = bus.in_valid
                  & w_in_ready
                  & ~bus.in_abort;

  assign w_done = w_accept & (r_cnt == LAST);

  // Top bit of slot r_cnt; slot 0 is the MSB byte.
  assign w_msb = PTR_W'(BLK_W - 1)
               - PTR_W'(r_cnt) * PTR_W'(BYTE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_block <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (bus.in_abort) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_done) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc[w_msb -: BYTE_W] <= bus.in_byte;
      end

      // A completing block wins over a drain,
      // so valid stays high across back-to-back.
      if (w_done) begin
        r_out_block <= {r_acc[BLK_W-1:BYTE_W],
                        bus.in_byte};
        r_out_valid <= 1'b1;
      end else if (r_out_valid & bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_block  = r_out_block;
  assign bus.out_valid  = r_out_valid;
  assign bus.fill_count = r_cnt;

endmodule

// File: tb/tb_aes_byte_assembler.sv
// Self-checking bench for aes_byte_assembler.
// Vector table, hand sequences, scoreboard.
module tb_aes_byte_assembler;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_byte_assembler_if bus ();

  aes_byte_assembler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    byte_t  b [16];
    block_t exp;
  } vec_t;

  vec_t   vecs [6];
  block_t sb [$];
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     auto_sb = 1'b1;
  bit     rand_rdy = 1'b0;
  block_t m_acc = '0;
  int     m_cnt = 0;
  int     stalls = 0;
  block_t prev_blk = '0;
  bit     prev_stall = 1'b0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic send_byte(input byte_t b);
    int w;
    bit ok;
    w  = 0;
    ok = 1'b0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (!ok && w <= 1000) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else w++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not taken", b);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    stalls += w;
    bus.in_valid = 1'b0;
    m_acc = {m_acc[119:0], b};
    m_cnt++;
    if (m_cnt == 16) begin
      if (auto_sb) sb.push_back(m_acc);
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    m_cnt = 0;
    m_acc = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard, output stability and fill count.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_block", bus.out_block, prev_blk);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h expected none",
                   bus.out_block);
        end else begin
          chk("sb_block", bus.out_block, sb.pop_front());
        end
      end
      chk("fill_count", bus.fill_count, m_cnt);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_blk   = bus.out_block;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[0].b[i] = byte_t'(i * 8'h11);
      vecs[1].b[i] = byte_t'(8'h10 + i);
      vecs[2].b[i] = 8'hff;
      vecs[3].b[i] = byte_t'(i);
      vecs[4].b[i] = byte_t'(8'hf0 - i);
      vecs[5].b[i] = (i % 2 == 0) ? 8'ha5 : 8'h5a;
    end
    vecs[0].exp = 128'h00112233445566778899aabbccddeeff;
    vecs[1].exp = 128'h101112131415161718191a1b1c1d1e1f;
    vecs[2].exp = {128{1'b1}};
    vecs[3].exp = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[4].exp = 128'hf0efeeedecebeae9e8e7e6e5e4e3e2e1;
    vecs[5].exp = 128'ha55aa55aa55aa55aa55aa55aa55aa55a;

    bus.in_byte   = '0;
    bus.in_valid  = 1'b0;
    bus.in_abort  = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_fill", bus.fill_count, 0);
    chk("rst_block", bus.out_block, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Vector table, back-to-back bytes.
    auto_sb = 1'b0;
    for (int v = 0; v < 6; v++) begin
      sb.push_back(vecs[v].exp);
      for (int i = 0; i < 16; i++) send_byte(vecs[v].b[i]);
      if (v == 0) begin
        @(negedge clk);
        chk("fips_valid_n1", bus.out_valid, 1);
        @(negedge clk);
        chk("fips_valid_pulse", bus.out_valid, 0);
        @(posedge clk);
        #1;
      end
    end
    idle(2);
    chk("table_sb_empty", sb.size(), 0);

    // Backpressure: 32 bytes, consumer stalled.
    auto_sb = 1'b1;
    bus.out_ready = 1'b0;
    stalls = 0;
    for (int i = 0; i < 31; i++) send_byte(byte_t'(8'h20 + i));
    chk("bp_no_stall", stalls, 0);
    bus.in_byte  = 8'h3f;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_block1",
          bus.out_block,
          128'h202122232425262728292a2b2c2d2e2f);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_byte(8'h3f);
    idle(3);
    chk("bp_sb_empty", sb.size(), 0);

    // Abort mid-block with a byte presented.
    auto_sb = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(byte_t'(8'hc0 + i));
    @(negedge clk);
    chk("abort_pre_fill", bus.fill_count, 5);
    @(posedge clk);
    #1;
    bus.in_byte  = 8'haa;
    bus.in_valid = 1'b1;
    bus.in_abort = 1'b1;
    @(posedge clk);
    #1;
    bus.in_abort = 1'b0;
    bus.in_valid = 1'b0;
    m_cnt = 0;
    m_acc = '0;
    @(negedge clk);
    chk("abort_fill", bus.fill_count, 0);
    chk("abort_no_out", bus.out_valid, 0);
    @(posedge clk);
    #1;
    sb.push_back(128'h101112131415161718191a1b1c1d1e1f);
    for (int i = 0; i < 16; i++) send_byte(byte_t'(8'h10 + i));
    idle(2);
    chk("abort_sb_empty", sb.size(), 0);

    // Drain and complete on the same edge.
    auto_sb = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(byte_t'(8'h30 + i));
    for (int i = 0; i < 15; i++) send_byte(byte_t'(8'h50 + i));
    bus.out_ready = 1'b1;
    send_byte(8'h5f);
    @(negedge clk);
    chk("dc_valid", bus.out_valid, 1);
    chk("dc_block",
        bus.out_block,
        128'h505152535455565758595a5b5c5d5e5f);
    idle(2);
    chk("dc_sb_empty", sb.size(), 0);

    // Reset with a held block and a partial one.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(byte_t'(8'h60 + i));
    for (int i = 0; i < 9; i++) send_byte(byte_t'(8'h80 + i));
    do_reset();
    @(negedge clk);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_fill", bus.fill_count, 0);
    chk("mrst_block", bus.out_block, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    auto_sb = 1'b0;
    sb.push_back(128'h707172737475767778797a7b7c7d7e7f);
    for (int i = 0; i < 16; i++) send_byte(byte_t'(8'h70 + i));
    idle(2);
    chk("mrst_sb_empty", sb.size(), 0);

    // Random gaps on both sides.
    auto_sb  = 1'b1;
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.in_byte = byte_t'($urandom);
          idle($urandom_range(1, 2));
        end
        send_byte(byte_t'($urandom));
      end
    end
    @(posedge clk);
    #1;
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
    idle(2);
    chk("rand_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
